// File: rtl/conv_seq_pkg.sv
// Shared types and constants for the convg8 frame sequencer.
package conv_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        FLUSH,
        DRAIN
    } state_t;

    localparam int ROWEND_FIRST_BIT = 0;
    localparam int ROWEND_LAST_BIT  = 1;

    function automatic int beats_per_row(input int im_len, input int parallel_units);
        return im_len / parallel_units;
    endfunction

endpackage

// File: rtl/conv_seq_cnt.sv
// Column/row beat counter for the sequencer; steps on each datapath advance.
module conv_seq_cnt #(
    parameter  int COLS    = 2,
    parameter  int ROW_MAX = 4,
    localparam int COL_W   = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int ROW_W   = $clog2(ROW_MAX + 1)
) (
    input  logic             clk,
    input  logic             res,
    input  logic             en,
    input  logic             clr,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             col_wrap
);

    assign col_wrap = en & (col == COL_W'(COLS - 1));

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (en) begin
            if (col_wrap) begin
                col <= '0;
                row <= row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Frame sequencer driving the convg8 datapath: clear, run, bottom-pad flush, drain.
// Optional CONV_SEQ_ABORT_EN adds an abort input that clears and returns to IDLE.
module conv_seq_ctrl
    import conv_seq_pkg::*;
#(
    parameter int IM_LEN            = 520,
    parameter int IM_HEIGHT         = 520,
    parameter int NO_PARALLEL_UNITS = 4
) (
    input  logic       clk,
    input  logic       res,
`ifdef CONV_SEQ_ABORT_EN
    input  logic       abort,
`endif
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       clrbuffer,
    output logic [1:0] rowend,
    output logic       stall,
    output logic       busy,
    output logic       done
);

    localparam int B       = beats_per_row(IM_LEN, NO_PARALLEL_UNITS);
    localparam int LAT     = B + 1;
    localparam int TOTAL   = IM_HEIGHT * B + LAT;
    localparam int CNT_W   = $clog2(TOTAL);
    localparam int ROW_MAX = IM_HEIGHT + 2;
    localparam int COL_W   = (B > 1) ? $clog2(B) : 1;
    localparam int ROW_W   = $clog2(ROW_MAX + 1);

    generate
        if ((IM_LEN % NO_PARALLEL_UNITS) != 0) begin : g_len_check
            $error("IM_LEN must be a multiple of NO_PARALLEL_UNITS");
        end
    endgenerate

    state_t             state, state_nxt;
    logic               adv, hold, hs, active, abort_act, to_idle;
    logic               cnt_clr, col_wrap, last_in, last_flush;
    logic [CNT_W-1:0]   adv_cnt;
    logic [COL_W-1:0]   col;
    logic [ROW_W-1:0]   row;

`ifdef CONV_SEQ_ABORT_EN
    assign abort_act = abort & (state != IDLE);

    // Remembers that the CLEAR cycle in progress was forced by abort.
    always_ff @(posedge clk or posedge res) begin
        if (res)
            to_idle <= 1'b0;
        else if (abort_act)
            to_idle <= 1'b1;
        else if (state == CLEAR)
            to_idle <= 1'b0;
    end
`else
    assign abort_act = 1'b0;
    assign to_idle   = 1'b0;
`endif

    assign hs        = out_valid & out_ready;
    assign hold      = out_valid & ~out_ready;
    assign adv       = ~hold & ~abort_act & (((state == RUN) & in_valid) | (state == FLUSH));
    assign in_ready  = (state == RUN) & ~hold & ~abort_act;
    assign stall     = ~adv;
    assign busy      = (state != IDLE);
    assign clrbuffer = (state == CLEAR);
    assign active    = (state == RUN) | (state == FLUSH);
    assign cnt_clr   = (state == IDLE) | (state == CLEAR) | abort_act;

    // rowend is active-low per bit and reads 00 whenever the datapath is not stepping a frame.
    assign rowend[ROWEND_LAST_BIT]  = active & (col != COL_W'(B - 1));
    assign rowend[ROWEND_FIRST_BIT] = active & (col != '0);

    assign last_in    = (state == RUN) & col_wrap & (row == ROW_W'(IM_HEIGHT - 1));
    assign last_flush = (state == FLUSH) & adv & (adv_cnt == CNT_W'(TOTAL - 1));

    conv_seq_cnt #(
        .COLS    (B),
        .ROW_MAX (ROW_MAX)
    ) u_cnt (
        .clk      (clk),
        .res      (res),
        .en       (adv),
        .clr      (cnt_clr),
        .col      (col),
        .row      (row),
        .col_wrap (col_wrap)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CLEAR;
            CLEAR:   state_nxt = to_idle ? IDLE : RUN;
            RUN:     if (last_in) state_nxt = FLUSH;
            FLUSH:   if (last_flush) state_nxt = DRAIN;
            DRAIN:   if (hs) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort_act)
            state_nxt = CLEAR;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state     <= IDLE;
            done      <= 1'b0;
            out_valid <= 1'b0;
            adv_cnt   <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) & hs & ~abort_act;
            // The first LAT advances only prime the line buffers.
            if (abort_act)
                out_valid <= 1'b0;
            else if (adv && (adv_cnt >= CNT_W'(LAT)))
                out_valid <= 1'b1;
            else if (hs)
                out_valid <= 1'b0;
            if (cnt_clr)
                adv_cnt <= '0;
            else if (adv)
                adv_cnt <= last_flush ? '0 : adv_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Directed bench for conv_seq_ctrl with an 8x3 image, 4 pixels per beat (B=2, LAT=3).
module tb_conv_seq_ctrl;

    logic       clk = 1'b0;
    logic       res = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
`ifdef CONV_SEQ_ABORT_EN
    logic       abort = 1'b0;
`endif
    logic       in_ready, out_valid, clrbuffer, stall, busy, done;
    logic [1:0] rowend;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    conv_seq_ctrl #(
        .IM_LEN            (8),
        .IM_HEIGHT         (3),
        .NO_PARALLEL_UNITS (4)
    ) dut (
        .clk       (clk),
        .res       (res),
`ifdef CONV_SEQ_ABORT_EN
        .abort     (abort),
`endif
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .clrbuffer (clrbuffer),
        .rowend    (rowend),
        .stall     (stall),
        .busy      (busy),
        .done      (done)
    );

    // Event monitor sampled mid-cycle
    int          cyc = 0, tot_adv = 0, tot_acc = 0, tot_hs = 0, tot_ov = 0;
    int          tot_done = 0, tot_clr = 0, last_hs_cyc = 0, last_done_cyc = 0;
    logic        last_done_busy = 1'b1;
    logic [63:0] rowend_hist = '0;
    int          adv_cyc_at [256];
    int          ov_cyc_at  [256];

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (!stall) begin
            adv_cyc_at[tot_adv % 256] <= cyc;
            tot_adv     <= tot_adv + 1;
            rowend_hist <= {rowend_hist[61:0], rowend};
        end
        if (in_ready && in_valid) tot_acc <= tot_acc + 1;
        if (out_valid) begin
            ov_cyc_at[tot_ov % 256] <= cyc;
            tot_ov <= tot_ov + 1;
        end
        if (out_valid && out_ready) begin
            tot_hs      <= tot_hs + 1;
            last_hs_cyc <= cyc;
        end
        if (done) begin
            tot_done       <= tot_done + 1;
            last_done_cyc  <= cyc;
            last_done_busy <= busy;
        end
        if (clrbuffer) tot_clr <= tot_clr + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        int c0;
        in_valid = 1'b0; out_ready = 1'b1; res = 1'b1;
        tick(); tick();
        // {in_ready,out_valid,clrbuffer,rowend,stall,busy,done}
        vecs++;
        if ({in_ready, out_valid, clrbuffer, rowend, stall, busy, done} !== 8'b0000_0100) begin
            errs++;
            $display("FAIL reset_outputs: got %b, want 00000100",
                     {in_ready, out_valid, clrbuffer, rowend, stall, busy, done});
        end
        res = 1'b0;
        tick();
        pulse_start();
        vecs++;
        if (clrbuffer !== 1'b1) begin errs++; $display("FAIL clr_after_start: got %b, want 1", clrbuffer); end
        vecs++;
        if (in_ready !== 1'b0) begin errs++; $display("FAIL in_ready_clear: got %b, want 0", in_ready); end
        in_valid = 1'b1;
        tick();
        vecs++;
        if (in_ready !== 1'b1) begin errs++; $display("FAIL in_ready_first: got %b, want 1", in_ready); end
        tick(); tick();
        #2; res = 1'b1; #1;
        vecs++;
        if ({in_ready, out_valid, clrbuffer, rowend, stall, busy, done} !== 8'b0000_0100) begin
            errs++;
            $display("FAIL reset_midrun: got %b, want 00000100",
                     {in_ready, out_valid, clrbuffer, rowend, stall, busy, done});
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        res = 1'b0;
        tick();
        c0 = tot_clr;
        pulse_start();
        repeat (4) tick();
        vecs++;
        if (tot_clr - c0 !== 1) begin errs++; $display("FAIL clr_cycles: got %0d, want 1", tot_clr - c0); end
        res = 1'b1; tick(); res = 1'b0; tick();
    endtask

    task automatic test_stream();
        int adv0, acc0, hs0, ov0, d0, n;
        adv0 = tot_adv; acc0 = tot_acc; hs0 = tot_hs; ov0 = tot_ov; d0 = tot_done;
        in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        n = 0;
        while (tot_done == d0 && n < 60) begin tick(); n++; end
        in_valid = 1'b0;
        vecs++;
        if (tot_acc - acc0 !== 6) begin errs++; $display("FAIL stream_accepted: got %0d, want 6", tot_acc - acc0); end
        vecs++;
        if (tot_adv - adv0 !== 9) begin errs++; $display("FAIL stream_advances: got %0d, want 9", tot_adv - adv0); end
        vecs++;
        if (rowend_hist[17:0] !== 18'b10_01_10_01_10_01_10_01_10) begin
            errs++; $display("FAIL stream_rowend: got %b, want 100110011001100110", rowend_hist[17:0]);
        end
        vecs++;
        if (tot_ov - ov0 !== 6) begin errs++; $display("FAIL stream_ov_cycles: got %0d, want 6", tot_ov - ov0); end
        vecs++;
        if (tot_hs - hs0 !== 6) begin errs++; $display("FAIL stream_outputs: got %0d, want 6", tot_hs - hs0); end
        vecs++;
        if (ov_cyc_at[ov0 % 256] !== adv_cyc_at[(adv0 + 3) % 256] + 1) begin
            errs++;
            $display("FAIL stream_first_out: got cycle %0d, want %0d",
                     ov_cyc_at[ov0 % 256], adv_cyc_at[(adv0 + 3) % 256] + 1);
        end
        vecs++;
        if (tot_done - d0 !== 1) begin errs++; $display("FAIL stream_done: got %0d, want 1", tot_done - d0); end
        vecs++;
        if (last_done_cyc !== last_hs_cyc + 1) begin
            errs++; $display("FAIL stream_done_cycle: got %0d, want %0d", last_done_cyc, last_hs_cyc + 1);
        end
        vecs++;
        if (last_done_busy !== 1'b0) begin errs++; $display("FAIL stream_busy_at_done: got %b, want 0", last_done_busy); end
    endtask

    task automatic test_stall();
        int hs0, d0, acc0, n;
        logic [4:0] iv_pat;
        logic [1:0] exp_re [5];
        iv_pat = 5'b10101;
        exp_re = '{2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
        hs0 = tot_hs; d0 = tot_done; acc0 = tot_acc;
        in_valid = 1'b0; out_ready = 1'b1;
        pulse_start();
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = iv_pat[4-i];
            #1;
            vecs++;
            if (stall !== ~iv_pat[4-i]) begin errs++; $display("FAIL stall_step%0d: got %b, want %b", i, stall, ~iv_pat[4-i]); end
            vecs++;
            if (rowend !== exp_re[i]) begin errs++; $display("FAIL rowend_step%0d: got %b, want %b", i, rowend, exp_re[i]); end
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        n = 0;
        while (tot_done == d0 && n < 60) begin tick(); n++; end
        in_valid = 1'b0;
        vecs++;
        if (tot_acc - acc0 !== 6) begin errs++; $display("FAIL stall_accepted: got %0d, want 6", tot_acc - acc0); end
        vecs++;
        if (tot_hs - hs0 !== 6) begin errs++; $display("FAIL stall_outputs: got %0d, want 6", tot_hs - hs0); end
        vecs++;
        if (tot_done - d0 !== 1) begin errs++; $display("FAIL stall_done: got %0d, want 1", tot_done - d0); end
    endtask

    task automatic test_backpressure();
        int adv0, acc0, hs0, ov0, d0, n, held;
        adv0 = tot_adv; acc0 = tot_acc; hs0 = tot_hs; ov0 = tot_ov; d0 = tot_done;
        in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        n = 0; held = 0;
        while (tot_done == d0 && n < 80) begin
            if (out_valid && (tot_hs - hs0) == 1 && held < 4) begin
                out_ready = 1'b0;
                held++;
                #1;
                vecs++;
                if ({in_ready, stall, out_valid} !== 3'b011) begin
                    errs++; $display("FAIL bp_hold%0d: got %b, want 011", held, {in_ready, stall, out_valid});
                end
            end else begin
                out_ready = 1'b1;
            end
            tick();
            n++;
        end
        out_ready = 1'b1; in_valid = 1'b0;
        vecs++;
        if (held !== 4) begin errs++; $display("FAIL bp_held_cycles: got %0d, want 4", held); end
        vecs++;
        if (tot_hs - hs0 !== 6) begin errs++; $display("FAIL bp_outputs: got %0d, want 6", tot_hs - hs0); end
        vecs++;
        if (tot_ov - ov0 !== 10) begin errs++; $display("FAIL bp_ov_cycles: got %0d, want 10", tot_ov - ov0); end
        vecs++;
        if (tot_adv - adv0 !== 9) begin errs++; $display("FAIL bp_advances: got %0d, want 9", tot_adv - adv0); end
        vecs++;
        if (tot_acc - acc0 !== 6) begin errs++; $display("FAIL bp_accepted: got %0d, want 6", tot_acc - acc0); end
        vecs++;
        if (tot_done - d0 !== 1) begin errs++; $display("FAIL bp_done: got %0d, want 1", tot_done - d0); end
    endtask

    task automatic test_start_ignored();
        int hs0, d0, c0, n;
        hs0 = tot_hs; d0 = tot_done; c0 = tot_clr;
        in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        tick(); tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (tot_done == d0 && n < 60) begin tick(); n++; end
        in_valid = 1'b0;
        repeat (6) tick();
        vecs++;
        if (tot_hs - hs0 !== 6) begin errs++; $display("FAIL restart_outputs: got %0d, want 6", tot_hs - hs0); end
        vecs++;
        if (tot_done - d0 !== 1) begin errs++; $display("FAIL restart_done: got %0d, want 1", tot_done - d0); end
        vecs++;
        if (tot_clr - c0 !== 1) begin errs++; $display("FAIL restart_clr: got %0d, want 1", tot_clr - c0); end
        vecs++;
        if (busy !== 1'b0) begin errs++; $display("FAIL restart_idle: got %b, want 0", busy); end
    endtask

`ifdef CONV_SEQ_ABORT_EN
    task automatic test_abort();
        int hs0, d0, c0, adv0, hs_at, n;
        hs0 = tot_hs; d0 = tot_done; c0 = tot_clr;
        in_valid = 1'b1; out_ready = 1'b1;
        pulse_start();
        n = 0;
        while ((tot_hs - hs0) < 2 && n < 40) begin tick(); n++; end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        vecs++;
        if ({clrbuffer, out_valid, busy} !== 3'b101) begin
            errs++; $display("FAIL abort_clear: got %b, want 101", {clrbuffer, out_valid, busy});
        end
        hs_at = tot_hs;
        tick();
        vecs++;
        if ({clrbuffer, busy} !== 2'b00) begin errs++; $display("FAIL abort_idle: got %b, want 00", {clrbuffer, busy}); end
        repeat (5) tick();
        vecs++;
        if (tot_clr - c0 !== 2) begin errs++; $display("FAIL abort_clr_count: got %0d, want 2", tot_clr - c0); end
        vecs++;
        if (tot_done - d0 !== 0) begin errs++; $display("FAIL abort_no_done: got %0d, want 0", tot_done - d0); end
        vecs++;
        if (tot_hs !== hs_at) begin errs++; $display("FAIL abort_no_output: got %0d, want %0d", tot_hs, hs_at); end
        hs0 = tot_hs; d0 = tot_done; adv0 = tot_adv;
        pulse_start();
        n = 0;
        while (tot_done == d0 && n < 60) begin tick(); n++; end
        in_valid = 1'b0;
        vecs++;
        if (tot_hs - hs0 !== 6) begin errs++; $display("FAIL abort_next_outputs: got %0d, want 6", tot_hs - hs0); end
        vecs++;
        if (tot_adv - adv0 !== 9) begin errs++; $display("FAIL abort_next_advances: got %0d, want 9", tot_adv - adv0); end
        vecs++;
        if (tot_done - d0 !== 1) begin errs++; $display("FAIL abort_next_done: got %0d, want 1", tot_done - d0); end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_backpressure();
        test_start_ignored();
`ifdef CONV_SEQ_ABORT_EN
        test_abort();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
